uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between NUM_REQ byte requesters using round-robin arbitration.
- Accepts one byte from the winning requester and drives the UART's tx_rx_start and tx_data.
- Tracks the UART busy flag through the whole frame, then frees the transmitter for the next grant.
- Sits between the requesting blocks and the UART TX side of the UART interface bundle.

---
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte requesters; optional start-to-busy watchdog under UART_ARB_TIMEOUT_EN.
// Latency: req_ready and accept in the same IDLE cycle; tx_rx_start is high the cycle after accept.
// Backpressure: a requester holds req_valid until it sees its req_ready; no grant while busy, disabled, or a frame is in progress.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tx_rx_enable,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_rx_start,
    output logic [7:0]                 tx_data,
    input  logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       err_timeout
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t         state;
    logic [IDW-1:0] last;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic           any_vld;
    logic           grant_vld;
    int             idx;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        any_vld = 1'b0;
        win     = '0;
        cand    = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(last) + k) % NUM_REQ;
            cand = IDW'(idx);
            if (!any_vld && req_valid[cand]) begin
                any_vld = 1'b1;
                win     = cand;
            end
        end
    end

    assign grant_vld = (state == IDLE) && tx_rx_enable && !busy && any_vld;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_vld && (win == IDW'(i));
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] to_cnt;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last        <= IDW'(NUM_REQ - 1);
            tx_rx_start <= 1'b0;
            tx_data     <= 8'h00;
            grant_id    <= '0;
            active      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt      <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            tx_rx_start <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        tx_data     <= req_data[{win, 3'b000} +: 8];
                        grant_id    <= win;
                        last        <= win;
                        active      <= 1'b1;
                        tx_rx_start <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    // A UART that raises busy during the start cycle skips the wait.
                    if (busy) begin
                        state <= WAIT_DONE;
                    end else begin
                        state <= WAIT_BUSY;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                WAIT_BUSY: begin
                    if (busy) begin
                        state <= WAIT_DONE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (to_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        err_timeout <= 1'b1;
                        active      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!busy) begin
                        active <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant timing, round-robin order, busy/enable gating, reset mid-frame, optional timeout.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_rx_enable = 1'b1;
    logic [3:0]  req_valid = 4'b0000;
    logic [31:0] req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    logic [3:0]  req_ready;
    logic        tx_rx_start;
    logic [7:0]  tx_data;
    logic        busy = 1'b0;
    logic [1:0]  grant_id;
    logic        active;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_rx_enable (tx_rx_enable),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .tx_rx_start  (tx_rx_start),
        .tx_data      (tx_data),
        .busy         (busy),
        .grant_id     (grant_id),
        .active       (active),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // UART stand-in: waits for the start pulse, then runs a short busy frame.
    task automatic uart_frame(output logic [7:0] d, output logic [1:0] id, output bit seen);
        seen = 1'b0;
        d    = 8'h00;
        id   = 2'd0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (tx_rx_start) begin
                seen = 1'b1;
                d    = tx_data;
                id   = grant_id;
            end
        end
        if (seen) begin
            tick();
            busy = 1'b1;
            repeat (3) tick();
            busy = 1'b0;
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        busy = 1'b0;
        req_valid = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({tx_rx_start, tx_data, grant_id, active, req_ready, err_timeout} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs got start=%b data=%h id=%0d act=%b rdy=%b err=%b required all zero",
                     tx_rx_start, tx_data, grant_id, active, req_ready, err_timeout);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req_valid = 4'b0001;
        req_data  = {8'h43, 8'h32, 8'h21, 8'hA5};
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready got %b required 0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        checks++;
        if (req_ready !== 4'b0000 || tx_rx_start !== 1'b1 || tx_data !== 8'hA5 || grant_id !== 2'd0 || active !== 1'b1) begin
            errors++;
            $display("FAIL single_start got rdy=%b start=%b data=%h id=%0d act=%b required 0000 1 a5 0 1",
                     req_ready, tx_rx_start, tx_data, grant_id, active);
        end
        tick();
        checks++;
        if (tx_rx_start !== 1'b0) begin
            errors++;
            $display("FAIL single_start_width got %b required 0", tx_rx_start);
        end
        tick();
        busy = 1'b1;
        repeat (10) tick();
        busy = 1'b0;
        #1;
        checks++;
        if (active !== 1'b1 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_active_hold got act=%b data=%h required 1 a5", active, tx_data);
        end
        tick();
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL single_active_fall got %b required 0", active);
        end
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
        logic [3:0] exp_r [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0] d;
        logic [1:0] id;
        bit         seen;
        do_reset();
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            #1;
            checks++;
            if (req_ready !== exp_r[g]) begin
                errors++;
                $display("FAIL rr_ready[%0d] got %b required %b", g, req_ready, exp_r[g]);
            end
            uart_frame(d, id, seen);
            checks++;
            if (!seen || d !== exp_d[g]) begin
                errors++;
                $display("FAIL rr_byte[%0d] got seen=%b data=%h required %h", g, seen, d, exp_d[g]);
            end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_busy_idle();
        logic [7:0] d;
        logic [1:0] id;
        bit         seen;
        busy = 1'b1;
        req_valid = 4'b0010;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (req_ready !== 4'b0000 || active !== 1'b0) begin
                errors++;
                $display("FAIL busy_idle_hold[%0d] got rdy=%b act=%b required 0000 0", n, req_ready, active);
            end
        end
        busy = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL busy_idle_release got %b required 0010", req_ready);
        end
        uart_frame(d, id, seen);
        req_valid = 4'b0000;
        checks++;
        if (!seen || d !== 8'h21 || id !== 2'd1) begin
            errors++;
            $display("FAIL busy_idle_byte got seen=%b data=%h id=%0d required 21 1", seen, d, id);
        end
    endtask

    task automatic test_enable();
        logic [7:0] d;
        logic [1:0] id;
        bit         seen;
        tx_rx_enable = 1'b0;
        req_valid = 4'b0100;
        repeat (3) tick();
        checks++;
        if (req_ready !== 4'b0000 || active !== 1'b0) begin
            errors++;
            $display("FAIL enable_block got rdy=%b act=%b required 0000 0", req_ready, active);
        end
        tx_rx_enable = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL enable_grant got %b required 0100", req_ready);
        end
        tick();
        tx_rx_enable = 1'b0;
        req_valid = 4'b1000;
        checks++;
        if (tx_rx_start !== 1'b1 || tx_data !== 8'h32) begin
            errors++;
            $display("FAIL enable_frame_start got start=%b data=%h required 1 32", tx_rx_start, tx_data);
        end
        tick();
        busy = 1'b1;
        repeat (3) tick();
        busy = 1'b0;
        tick();
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL enable_frame_done got act=%b required 0", active);
        end
        repeat (2) tick();
        checks++;
        if (req_ready !== 4'b0000 || tx_rx_start !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL enable_still_blocked got rdy=%b start=%b act=%b required 0000 0 0", req_ready, tx_rx_start, active);
        end
        tx_rx_enable = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL enable_regrant got %b required 1000", req_ready);
        end
        uart_frame(d, id, seen);
        req_valid = 4'b0000;
        checks++;
        if (!seen || d !== 8'h43 || id !== 2'd3) begin
            errors++;
            $display("FAIL enable_byte got seen=%b data=%h id=%0d required 43 3", seen, d, id);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        logic [1:0] id;
        bit         seen;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        busy = 1'b1;
        tick();
        checks++;
        if (active !== 1'b1 || grant_id !== 2'd0 || tx_data !== 8'h10) begin
            errors++;
            $display("FAIL midrst_pre got act=%b id=%0d data=%h required 1 0 10", active, grant_id, tx_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({tx_rx_start, tx_data, grant_id, active, req_ready, err_timeout} !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_outputs got start=%b data=%h id=%0d act=%b rdy=%b err=%b required all zero",
                     tx_rx_start, tx_data, grant_id, active, req_ready, err_timeout);
        end
        tick();
        rst = 1'b0;
        req_valid = 4'b0010;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (req_ready !== 4'b0000 || tx_rx_start !== 1'b0) begin
                errors++;
                $display("FAIL midrst_hold[%0d] got rdy=%b start=%b required 0000 0", n, req_ready, tx_rx_start);
            end
        end
        busy = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL midrst_grant got %b required 0010", req_ready);
        end
        uart_frame(d, id, seen);
        req_valid = 4'b0000;
        checks++;
        if (!seen || d !== 8'h21) begin
            errors++;
            $display("FAIL midrst_byte got seen=%b data=%h required 21", seen, d);
        end
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] d;
        logic [1:0] id;
        bit         seen;
        int         n;
        int         pulses;
        req_valid = 4'b1100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL to_grant got %b required 0100", req_ready);
        end
        tick();
        req_valid = 4'b1000;
        tick();
        n = 0;
        while (n < 40 && err_timeout !== 1'b1) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 16 || active !== 1'b0 || req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL to_pulse got cycles=%0d act=%b rdy=%b required 16 0 1000", n, active, req_ready);
        end
        pulses = 1;
        uart_frame(d, id, seen);
        req_valid = 4'b0000;
        checks++;
        if (!seen || d !== 8'h43 || id !== 2'd3) begin
            errors++;
            $display("FAIL to_next_byte got seen=%b data=%h id=%0d required 43 3", seen, d, id);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (err_timeout === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL to_single_pulse got %0d pulses required 1", pulses);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_busy_idle();
        test_enable();
        test_reset_mid_frame();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
